// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM} loader_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, word write strobe out
// master is the loader side (consumes bytes, drives memory writes); slave is its environment.
interface imem_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - little-endian byte to 32-bit word assembly
// Lanes 0..2 are held in registers; the lane-3 byte completes the word combinationally.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [1:0]  lane_idx,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] lanes;

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes <= 24'd0;
        end else if (byte_valid) begin
            case (lane_idx)
                2'd0:    lanes[7:0]   <= byte_data;
                2'd1:    lanes[15:8]  <= byte_data;
                2'd2:    lanes[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    assign word       = {byte_data, lanes};
    assign word_valid = byte_valid && (lane_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed, checksummed byte frame into instruction memory
// The core is held in reset for the whole load; the result is reported with a done pulse and a sticky err.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    loader_state_e state;
    logic [15:0]   len;
    logic [15:0]   word_idx;
    logic [1:0]    lane_idx;
    logic [7:0]    sum;

    logic          hs;
    logic          data_hs;
    logic          word_valid;
    logic [31:0]   word;
    logic [15:0]   len_full;
    logic [7:0]    sum_next;
    logic          len_bad;

    assign hs       = bus.rx_valid && bus.rx_ready;
    assign data_hs  = hs && (state == DATA);
    assign sum_next = sum + bus.rx_data;
    assign len_full = {bus.rx_data, len[7:0]};
    assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_W);

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (data_hs),
        .lane_idx   (lane_idx),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len           <= 16'd0;
            word_idx      <= 16'd0;
            lane_idx      <= 2'd0;
            sum           <= 8'd0;
            bus.rx_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err          <= 1'b0;
                        lane_idx     <= 2'd0;
                        word_idx     <= 16'd0;
                        sum          <= 8'd0;
                        state        <= LEN_LO;
                        bus.rx_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (hs) begin
                        len[7:0] <= bus.rx_data;
                        sum      <= sum_next;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (hs) begin
                        len <= len_full;
                        sum <= sum_next;
                        if (len_bad) begin
                            err          <= 1'b1;
                            done         <= 1'b1;
                            state        <= IDLE;
                            bus.rx_ready <= 1'b0;
                            cpu_hold     <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (hs) begin
                        sum      <= sum_next;
                        lane_idx <= lane_idx + 2'd1;
                        if (word_valid) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= word;
                            bus.mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx      <= word_idx + 16'd1;
                            if (word_idx == len - 16'd1) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (hs) begin
                        sum          <= sum_next;
                        err          <= (sum_next != 8'd0);
                        done         <= 1'b1;
                        state        <= IDLE;
                        bus.rx_ready <= 1'b0;
                        cpu_hold     <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.rx_ready <= 1'b0;
                    cpu_hold     <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
